// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the fetch-stage MDR sequencer.
//   fetch_state_e    : the eight sequencer states
//   INST_W           : width of the external instruction MDR
//   DEFAULT_*        : default address width, PC step and timeout
//   is_mem_pending() : true in the states that drive mem_req
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int INST_W          = 68;
    localparam int DEFAULT_ADDR_W  = 32;
    localparam int DEFAULT_PC_STEP = 4;
    localparam int DEFAULT_TIMEOUT = 15;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_LOAD  = 3'd3,
        ST_READ  = 3'd4,
        ST_VALID = 3'd5,
        ST_DRAIN = 3'd6,
        ST_FAULT = 3'd7
    } fetch_state_e;

    // The read request is held from issue until the acknowledge arrives.
    function automatic logic is_mem_pending(input fetch_state_e st);
        return (st == ST_REQ) || (st == ST_WAIT);
    endfunction

endpackage

// File: rtl/mdr_fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// mdr_fetch_ctrl_if
// Bus bundle between the fetch sequencer and its memory / MDR / decode peers.
//   mem_req, mem_addr   : instruction-memory read request and address
//   mem_ack             : memory data valid
//   MDR_wr, MDR_rd      : MDR capture / output-load strobes
//   inst_valid, pc_out  : instruction offered to decode and its PC
//   inst_ready          : decode accepts
// master = the sequencer, slave = the surrounding memory/MDR/decode side.
// -----------------------------------------------------------------------------
interface mdr_fetch_ctrl_if #(
    parameter int ADDR_W = fetch_pkg::DEFAULT_ADDR_W
) ();

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic              MDR_wr;
    logic              MDR_rd;
    logic              inst_valid;
    logic              inst_ready;
    logic [ADDR_W-1:0] pc_out;

    modport master (
        output mem_req, mem_addr, MDR_wr, MDR_rd, inst_valid, pc_out,
        input  mem_ack, inst_ready
    );

    modport slave (
        input  mem_req, mem_addr, MDR_wr, MDR_rd, inst_valid, pc_out,
        output mem_ack, inst_ready
    );

endinterface

// File: rtl/fetch_timeout_cnt.sv
// -----------------------------------------------------------------------------
// fetch_timeout_cnt
// 8-bit saturating wait-cycle counter for the memory acknowledge.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : restart the count at zero
//   inc_i      : one more cycle spent waiting
//   hit_o      : this cycle's increment brings the count to TIMEOUT
// -----------------------------------------------------------------------------
module fetch_timeout_cnt #(
    parameter int TIMEOUT = fetch_pkg::DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic hit_o
);

    logic [7:0] count_q;

    // Wait-cycle count register; saturates so a long drain never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 8'd0;
        end else if (clr_i) begin
            count_q <= 8'd0;
        end else if (inc_i && (count_q != 8'hFF)) begin
            count_q <= count_q + 8'd1;
        end else begin
            count_q <= count_q;
        end
    end

    // Expiry on the cycle that completes the TIMEOUT-th wait cycle; the
    // >= keeps expiry reachable if the count already passed TIMEOUT.
    always_comb begin
        if (inc_i && (({1'b0, count_q} + 9'd1) >= 9'(TIMEOUT))) begin
            hit_o = 1'b1;
        end else begin
            hit_o = 1'b0;
        end
    end

endmodule

// File: rtl/mdr_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// mdr_fetch_ctrl
// Fetch-stage sequencer for the 68-bit instruction MDR: reads memory at pc,
// strobes the MDR capture then output-load, offers the instruction to decode
// over valid/ready and advances pc. Supports branch-redirect flush and a
// sticky memory-timeout fault.
//   clk, rst_n  : clock, asynchronous active-low reset
//   enable      : permit new fetches
//   flush       : redirect pulse, flush_pc is the new pc
//   fault       : sticky timeout flag (cleared only by flush)
//   busy        : sequencer not idle
//   bus         : memory / MDR / decode bundle (master side)
// -----------------------------------------------------------------------------
module mdr_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = DEFAULT_ADDR_W,
    parameter int                PC_STEP  = DEFAULT_PC_STEP,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}},
    parameter int                TIMEOUT  = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    output logic              fault,
    output logic              busy,
    mdr_fetch_ctrl_if.master  bus
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              cnt_clr_s;
    logic              cnt_inc_s;
    logic              cnt_hit_s;
    logic              mem_req_s;
    logic              mdr_wr_s;
    logic              mdr_rd_s;
    logic              inst_valid_s;
    logic              fault_s;
    logic              busy_s;

    fetch_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (cnt_clr_s),
        .inc_i (cnt_inc_s),
        .hit_o (cnt_hit_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Program counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Next-state, next-pc and timeout-counter control.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cnt_clr_s = 1'b0;
        cnt_inc_s = 1'b0;

        // Issuing a request restarts the wait count.
        if (state_q == ST_REQ) begin
            cnt_clr_s = 1'b1;
        end else begin
            cnt_clr_s = 1'b0;
        end

        // Any cycle spent waiting for an acknowledge counts, draining included.
        if (((state_q == ST_WAIT) || (state_q == ST_DRAIN)) && !bus.mem_ack) begin
            cnt_inc_s = 1'b1;
        end else begin
            cnt_inc_s = 1'b0;
        end

        if (flush) begin
            pc_d = flush_pc;
            // A request still outstanding must be drained so that at most one
            // read is ever in flight; an ack arriving now is simply dropped.
            if ((state_q == ST_WAIT) && !bus.mem_ack) begin
                state_d = ST_DRAIN;
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_REQ: begin
                    state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.mem_ack) begin
                        state_d = ST_LOAD;
                    end else if (cnt_hit_s) begin
                        state_d = ST_FAULT;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                ST_LOAD: begin
                    state_d = ST_READ;
                end
                ST_READ: begin
                    state_d = ST_VALID;
                end
                ST_VALID: begin
                    if (bus.inst_ready) begin
                        pc_d = pc_q + ADDR_W'(PC_STEP);
                        if (enable) begin
                            state_d = ST_REQ;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        state_d = ST_VALID;
                    end
                end
                ST_DRAIN: begin
                    // Expiry here is silent: the flush already abandoned this read.
                    if (bus.mem_ack || cnt_hit_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Output decode: every output is a function of the state and pc registers.
    always_comb begin
        mem_req_s    = is_mem_pending(state_q);
        mdr_wr_s     = (state_q == ST_LOAD);
        mdr_rd_s     = (state_q == ST_READ);
        inst_valid_s = (state_q == ST_VALID);
        fault_s      = (state_q == ST_FAULT);
        busy_s       = (state_q != ST_IDLE);
    end

    assign bus.mem_req    = mem_req_s;
    assign bus.mem_addr   = pc_q;
    assign bus.MDR_wr     = mdr_wr_s;
    assign bus.MDR_rd     = mdr_rd_s;
    assign bus.inst_valid = inst_valid_s;
    assign bus.pc_out     = pc_q;
    assign fault          = fault_s;
    assign busy           = busy_s;

endmodule

// File: tb/tb_mdr_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mdr_fetch_ctrl
// Directed bench for mdr_fetch_ctrl: a vector table for the basic fetch and
// stall flow, plus hand-written sequences for timeout, flush/drain, PC wrap
// and asynchronous reset. A second instance uses RESET_PC = 0xFFFF_FFFC.
// -----------------------------------------------------------------------------
module tb_mdr_fetch_ctrl;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable, flush, fault, busy;
    logic [31:0] flush_pc;
    logic        enable_w, flush_w, fault_w, busy_w;
    logic [31:0] flush_pc_w;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mdr_fetch_ctrl_if #(.ADDR_W(32)) bus ();
    mdr_fetch_ctrl_if #(.ADDR_W(32)) bus_w ();

    mdr_fetch_ctrl #(.ADDR_W(32), .PC_STEP(4), .RESET_PC(32'h0000_0000), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush), .flush_pc(flush_pc),
        .fault(fault), .busy(busy), .bus(bus)
    );

    mdr_fetch_ctrl #(.ADDR_W(32), .PC_STEP(4), .RESET_PC(32'hFFFF_FFFC), .TIMEOUT(15)) dut_w (
        .clk(clk), .rst_n(rst_n), .enable(enable_w), .flush(flush_w), .flush_pc(flush_pc_w),
        .fault(fault_w), .busy(busy_w), .bus(bus_w)
    );

    typedef struct {
        logic        en, fl, ack, rdy;
        logic [31:0] fpc;
        logic        req, wr, rd, iv, flt, bsy;
        logic [31:0] pc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic en, input logic fl, input logic [31:0] fpc,
                                input logic ack, input logic rdy,
                                input logic req, input logic wr, input logic rd,
                                input logic iv, input logic flt, input logic bsy,
                                input logic [31:0] pc);
        vec_t v;
        v.en = en; v.fl = fl; v.fpc = fpc; v.ack = ack; v.rdy = rdy;
        v.req = req; v.wr = wr; v.rd = rd; v.iv = iv; v.flt = flt; v.bsy = bsy; v.pc = pc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_outs(input string n, input logic req, input logic wr, input logic rd,
                            input logic iv, input logic flt, input logic bsy, input logic [31:0] pc);
        chk({n, ".mem_req"},    bus.mem_req,    req);
        chk({n, ".MDR_wr"},     bus.MDR_wr,     wr);
        chk({n, ".MDR_rd"},     bus.MDR_rd,     rd);
        chk({n, ".inst_valid"}, bus.inst_valid, iv);
        chk({n, ".fault"},      fault,          flt);
        chk({n, ".busy"},       busy,           bsy);
        chk({n, ".mem_addr"},   bus.mem_addr,   pc);
        chk({n, ".pc_out"},     bus.pc_out,     pc);
    endtask

    // One complete fetch from IDLE with ack in the first WAIT cycle.
    task automatic do_fetch(input logic [31:0] p);
        enable = 1'b1;
        step();
        chk("fetch.req", bus.mem_req, 1'b1);
        chk("fetch.addr", bus.mem_addr, p);
        enable = 1'b0;
        step();
        chk("fetch.wait_req", bus.mem_req, 1'b1);
        bus.mem_ack = 1'b1;
        step();
        chk("fetch.wr_at_req_plus2", bus.MDR_wr, 1'b1);
        bus.mem_ack = 1'b0;
        step();
        chk("fetch.rd", bus.MDR_rd, 1'b1);
        chk("fetch.rd_no_wr", bus.MDR_wr, 1'b0);
        step();
        chk("fetch.valid_at_req_plus4", bus.inst_valid, 1'b1);
        chk("fetch.pc_out", bus.pc_out, p);
        bus.inst_ready = 1'b1;
        step();
        chk("fetch.valid_drop", bus.inst_valid, 1'b0);
        chk("fetch.idle", busy, 1'b0);
        chk("fetch.pc_next", bus.pc_out, p + 32'd4);
        bus.inst_ready = 1'b0;
    endtask

    initial begin
        int   first;
        logic req15, req_at, wr_seen;

        enable = 1'b0; flush = 1'b0; flush_pc = 32'h0;
        bus.mem_ack = 1'b0; bus.inst_ready = 1'b0;
        enable_w = 1'b0; flush_w = 1'b0; flush_pc_w = 32'h0;
        bus_w.mem_ack = 1'b0; bus_w.inst_ready = 1'b0;

        // Basic fetch, back-to-back fetch with a 6-cycle stall, enable drop,
        // flush in IDLE and flush in REQ.
        vecs.push_back(mk(1'b1,1'b0,32'h0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0));
        vecs.push_back(mk(1'b1,1'b0,32'h0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,32'h0));
        vecs.push_back(mk(1'b1,1'b0,32'h0,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,32'h0));
        vecs.push_back(mk(1'b1,1'b0,32'h0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,32'h0));
        vecs.push_back(mk(1'b1,1'b0,32'h0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,32'h0));
        vecs.push_back(mk(1'b1,1'b0,32'h0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,32'h0));
        vecs.push_back(mk(1'b1,1'b0,32'h0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,32'h4));
        vecs.push_back(mk(1'b1,1'b0,32'h0,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,32'h4));
        vecs.push_back(mk(1'b1,1'b0,32'h0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,32'h4));
        vecs.push_back(mk(1'b1,1'b0,32'h0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,32'h4));
        for (int i = 0; i < 6; i++)
            vecs.push_back(mk(1'b1,1'b0,32'h0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,32'h4));
        vecs.push_back(mk(1'b1,1'b0,32'h0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,32'h4));
        vecs.push_back(mk(1'b0,1'b0,32'h0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,32'h8));
        vecs.push_back(mk(1'b0,1'b0,32'h0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,32'h8));
        vecs.push_back(mk(1'b0,1'b0,32'h0,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,32'h8));
        vecs.push_back(mk(1'b0,1'b0,32'h0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,32'h8));
        vecs.push_back(mk(1'b0,1'b0,32'h0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,32'h8));
        vecs.push_back(mk(1'b0,1'b0,32'h0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,32'h8));
        vecs.push_back(mk(1'b0,1'b0,32'h0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'hC));
        vecs.push_back(mk(1'b0,1'b1,32'h40,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'hC));
        vecs.push_back(mk(1'b1,1'b0,32'h0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h40));
        vecs.push_back(mk(1'b0,1'b1,32'h80,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,32'h40));
        vecs.push_back(mk(1'b0,1'b0,32'h0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h80));

        // Reset state
        #12;
        chk_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("reset.wrap_pc", bus_w.pc_out, 32'hFFFF_FFFC);
        step();
        rst_n = 1'b1;

        // Vector table: compare outputs, then drive this cycle's inputs.
        for (int i = 0; i < vecs.size(); i++) begin
            chk_outs($sformatf("vec%0d", i), vecs[i].req, vecs[i].wr, vecs[i].rd,
                     vecs[i].iv, vecs[i].flt, vecs[i].bsy, vecs[i].pc);
            enable = vecs[i].en; flush = vecs[i].fl; flush_pc = vecs[i].fpc;
            bus.mem_ack = vecs[i].ack; bus.inst_ready = vecs[i].rdy;
            step();
        end
        enable = 1'b0; flush = 1'b0; bus.mem_ack = 1'b0; bus.inst_ready = 1'b0;

        // Timeout: no ack, fault on the 16th cycle after REQ.
        enable = 1'b1;
        step();
        chk("to.req", bus.mem_req, 1'b1);
        chk("to.addr", bus.mem_addr, 32'h80);
        enable = 1'b0;
        first = -1; req15 = 1'b0; req_at = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (k == 15) req15 = bus.mem_req;
            if (fault && first < 0) begin
                first = k;
                req_at = bus.mem_req;
            end
        end
        chk("to.fault_cycle", first, 32'd16);
        chk("to.req_before_fault", req15, 1'b1);
        chk("to.req_in_fault", req_at, 1'b0);
        chk("to.fault_sticky", fault, 1'b1);
        flush = 1'b1; flush_pc = 32'h100;
        step();
        flush = 1'b0;
        chk("to.fault_cleared", fault, 1'b0);
        chk("to.flush_pc", bus.pc_out, 32'h100);
        chk("to.idle", busy, 1'b0);
        do_fetch(32'h100);

        // Flush in WAIT, ack 3 cycles later: drained, no MDR capture.
        enable = 1'b1;
        step();
        enable = 1'b0;
        step();
        flush = 1'b1; flush_pc = 32'h40;
        step();
        flush = 1'b0;
        chk("drain.req_low", bus.mem_req, 1'b0);
        chk("drain.busy", busy, 1'b1);
        chk("drain.pc", bus.pc_out, 32'h40);
        chk("drain.valid_low", bus.inst_valid, 1'b0);
        step();
        chk("drain.wr1", bus.MDR_wr, 1'b0);
        step();
        chk("drain.wr2", bus.MDR_wr, 1'b0);
        chk("drain.still_busy", busy, 1'b1);
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        chk("drain.done_idle", busy, 1'b0);
        chk("drain.wr3", bus.MDR_wr, 1'b0);
        step();
        chk("drain.wr4", bus.MDR_wr, 1'b0);
        do_fetch(32'h40);

        // Flush together with ack in WAIT: ack discarded, straight to IDLE.
        enable = 1'b1;
        step();
        enable = 1'b0;
        step();
        flush = 1'b1; flush_pc = 32'h200; bus.mem_ack = 1'b1;
        step();
        flush = 1'b0; bus.mem_ack = 1'b0;
        chk("flack.idle", busy, 1'b0);
        chk("flack.wr", bus.MDR_wr, 1'b0);
        chk("flack.pc", bus.pc_out, 32'h200);
        step();
        chk("flack.wr_after", bus.MDR_wr, 1'b0);

        // Drain that never sees an ack expires to IDLE without fault.
        enable = 1'b1;
        step();
        enable = 1'b0;
        step();
        flush = 1'b1; flush_pc = 32'h300;
        step();
        flush = 1'b0;
        first = -1; wr_seen = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            step();
            wr_seen = wr_seen | bus.MDR_wr | fault;
            if (!busy && first < 0) first = k;
        end
        chk("dto.expire_cycle", first, 32'd14);
        chk("dto.no_fault_no_wr", wr_seen, 1'b0);
        chk("dto.pc", bus.pc_out, 32'h300);

        // PC wrap on the second instance.
        enable_w = 1'b1;
        step();
        chk("wrap.addr0", bus_w.mem_addr, 32'hFFFF_FFFC);
        enable_w = 1'b0;
        step();
        bus_w.mem_ack = 1'b1;
        step();
        bus_w.mem_ack = 1'b0;
        step();
        step();
        chk("wrap.valid", bus_w.inst_valid, 1'b1);
        chk("wrap.pc_out", bus_w.pc_out, 32'hFFFF_FFFC);
        bus_w.inst_ready = 1'b1; enable_w = 1'b1;
        step();
        bus_w.inst_ready = 1'b0; enable_w = 1'b0;
        chk("wrap.req", bus_w.mem_req, 1'b1);
        chk("wrap.addr1", bus_w.mem_addr, 32'h0);

        // Asynchronous reset in READ.
        enable = 1'b1;
        step();
        chk("ar.addr", bus.mem_addr, 32'h300);
        enable = 1'b0;
        step();
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        step();
        chk("ar.in_read", bus.MDR_rd, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_outs("ar.async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        step();
        rst_n = 1'b1;
        do_fetch(32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
